// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// One-bit full adder built from two half adders; the carry is the OR of the
// two half-adder carries (they can never both be set).

module hadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  hadder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  hadder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor. Operands are captured on start,
// one bit per clock is pushed LSB-first through a single full adder, and the
// result plus carry/overflow flags are registered when the last bit lands.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

  // Subtraction is A + ~B + 1: B is inverted at load and the carry seeded with sub.
  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; start is honoured in IDLE and DONE so ops can run back to back.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath and result registers. On the last bit, carry still holds
  // the carry into the MSB, so V is formed directly from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
    end else if (load) begin
      a_sh  <= A;
      b_sh  <= B ^ {WIDTH{sub}};
      r_sh  <= '0;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        S <= {fa_s, r_sh[WIDTH-1:1]};
        C <= fa_co;
        V <= carry ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=4).
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic       sub = 1'b0;
  logic       busy, done, C, V;
  logic [3:0] S;

  int total = 0;
  int bad   = 0;

  serial_add_sub #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sub(sub),
    .busy(busy), .done(done), .S(S), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  // Launch one op and watch 8 cycles; reports busy count, first done cycle,
  // number of done pulses and the result seen with the first done.
  task automatic op_run(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output int busy_cnt, output int done_cyc, output int n_done,
                        output logic [3:0] s_o, output logic c_o, output logic v_o);
    busy_cnt = 0; done_cyc = 0; n_done = 0; s_o = 'x; c_o = 'x; v_o = 'x;
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = cyc; s_o = S; c_o = C; v_o = V;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if ({S, C, V} !== 6'b0) begin bad++; $display("FAIL reset_scv got=%b want=000000", {S, C, V}); end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow;
    int bc, dc, nd; logic [3:0] s; logic c, v;
    op_run(4'd3, 4'd5, 1'b0, bc, dc, nd, s, c, v);
    total++; if (bc !== 4) begin bad++; $display("FAIL add_busy_cycles got=%0d want=4", bc); end
    total++; if (dc !== 5) begin bad++; $display("FAIL add_done_cycle got=%0d want=5", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL add_done_pulses got=%0d want=1", nd); end
    total++; if ({s, c, v} !== {4'b1000, 1'b0, 1'b1}) begin bad++; $display("FAIL add_3p5 got S=%b C=%b V=%b want S=1000 C=0 V=1", s, c, v); end
  endtask

  task automatic test_subtract;
    int bc, dc, nd; logic [3:0] s; logic c, v;
    op_run(4'd7, 4'd2, 1'b1, bc, dc, nd, s, c, v);
    total++; if ({s, c, v} !== {4'b0101, 1'b1, 1'b0}) begin bad++; $display("FAIL sub_7m2 got S=%b C=%b V=%b want S=0101 C=1 V=0", s, c, v); end
    op_run(4'd2, 4'd3, 1'b1, bc, dc, nd, s, c, v);
    total++; if ({s, c, v} !== {4'b1111, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_2m3 got S=%b C=%b V=%b want S=1111 C=0 V=0", s, c, v); end
    total++; if (dc !== 5) begin bad++; $display("FAIL sub_done_cycle got=%0d want=5", dc); end
    op_run(4'b1000, 4'd1, 1'b1, bc, dc, nd, s, c, v);
    total++; if ({s, c, v} !== {4'b0111, 1'b1, 1'b1}) begin bad++; $display("FAIL sub_8m1 got S=%b C=%b V=%b want S=0111 C=1 V=1", s, c, v); end
  endtask

  // 15+1 with start held through DONE; second op (1+1) starts without IDLE.
  task automatic test_back_to_back;
    logic [3:0] s1; logic c1, v1; logic b6, d6;
    int n_done = 0; int d2 = 0; logic [3:0] s2 = 'x; logic c2 = 1'bx, v2 = 1'bx;
    @(negedge clk);
    A = 4'd15; B = 4'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    s1 = 'x; c1 = 1'bx; v1 = 1'bx; b6 = 1'bx; d6 = 1'bx;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin A = 4'd1; B = 4'd1; end
      if (cyc == 6) begin start = 1'b0; b6 = busy; d6 = done; end
      if (done) n_done++;
      if (cyc == 5) begin s1 = S; c1 = C; v1 = V; end
      if (done && cyc > 5 && d2 == 0) begin d2 = cyc; s2 = S; c2 = C; v2 = V; end
    end
    total++; if ({s1, c1, v1} !== {4'b0000, 1'b1, 1'b0}) begin bad++; $display("FAIL wrap_15p1 got S=%b C=%b V=%b want S=0000 C=1 V=0", s1, c1, v1); end
    total++; if ({b6, d6} !== 2'b10) begin bad++; $display("FAIL b2b_no_idle got busy=%b done=%b want busy=1 done=0", b6, d6); end
    total++; if (d2 !== 10) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=10", d2); end
    total++; if ({s2, c2, v2} !== {4'b0010, 1'b0, 1'b0}) begin bad++; $display("FAIL b2b_1p1 got S=%b C=%b V=%b want S=0010 C=0 V=0", s2, c2, v2); end
    total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", n_done); end
  endtask

  task automatic test_start_ignored;
    int n_done = 0; int dc = 0; logic [3:0] s = 'x; logic c = 1'bx, v = 1'bx;
    @(negedge clk);
    A = 4'd3; B = 4'd5; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = (cyc == 2);
      if (cyc == 2) begin A = 4'd7; B = 4'd2; sub = 1'b1; end
      if (done) begin
        n_done++;
        if (dc == 0) begin dc = cyc; s = S; c = C; v = V; end
      end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL ignore_done_pulses got=%0d want=1", n_done); end
    total++; if ({s, c, v} !== {4'b1000, 1'b0, 1'b1}) begin bad++; $display("FAIL ignore_result got S=%b C=%b V=%b want S=1000 C=0 V=1", s, c, v); end
  endtask

  task automatic test_reset_mid;
    int bc, dc, nd; logic [3:0] s; logic c, v; int late_done = 0;
    @(negedge clk);
    A = 4'd7; B = 4'd2; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;   // RUN cycle 1
    @(negedge clk);                 // RUN cycle 2
    @(negedge clk); rst = 1'b1;     // RUN cycle 3
    @(negedge clk); rst = 1'b0;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rstmid_flags got busy=%b done=%b want 0 0", busy, done); end
    total++; if ({S, C, V} !== 6'b0) begin bad++; $display("FAIL rstmid_scv got=%b want=000000", {S, C, V}); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    total++; if (late_done !== 0) begin bad++; $display("FAIL rstmid_idle got=%0d active cycles want=0", late_done); end
    op_run(4'd7, 4'd2, 1'b1, bc, dc, nd, s, c, v);
    total++; if ({s, c, v} !== {4'b0101, 1'b1, 1'b0}) begin bad++; $display("FAIL rstmid_after got S=%b C=%b V=%b want S=0101 C=1 V=0", s, c, v); end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_subtract;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
